// File: rtl/zorro_buffer_sequencer.sv
// Zorro buffer enable/direction sequencer shared between slave accesses and NCR DMA mastering.
// Optional DATA-phase watchdog enabled by defining BUFFER_TIMEOUT_EN.
module zorro_buffer_sequencer #(
   parameter int unsigned TURN_CYCLES = 1,
   parameter int unsigned TIMEOUT     = 63
) (
   input  logic CLK,
   input  logic RESET,
   input  logic slave_req,
   input  logic slave_read,
   input  logic mstr_req,
   input  logic mstr_read,
   input  logic cycle_end,
   output logic slave_gnt,
   output logic mstr_gnt,
   output logic ABOEL_n,
   output logic ABOEH_n,
   output logic DBOE_n,
   output logic D2Z_n,
   output logic Z2D_n,
   output logic busy,
   output logic timeout
);

   typedef enum logic [1:0] {StIdle, StAddr, StData, StTurn} state_e;

   localparam logic [3:0] TurnMax = 4'(TURN_CYCLES);

   if (TURN_CYCLES == 0 || TURN_CYCLES > 15) begin : g_bad_turn
      $error("TURN_CYCLES must be in 1..15");
   end
   if (TIMEOUT == 0 || TIMEOUT > 63) begin : g_bad_timeout
      $error("TIMEOUT must be in 1..63");
   end

   state_e     state_q, state_d;
   logic       owner_slave_q, owner_slave_d;
   logic       last_slave_q, last_slave_d;
   // 1 = data flows NCR to Zorro (slave read or master write)
   logic       d2z_q, d2z_d;
   logic [3:0] turn_cnt_q, turn_cnt_d;
   logic       owner_req;
   logic       pick_slave;
   logic       tmo_fire;

`ifdef BUFFER_TIMEOUT_EN
   localparam logic [5:0] TmoLast = 6'(TIMEOUT - 1);
   logic [5:0] tmo_cnt_q, tmo_cnt_d;
`endif

   always_comb begin
      state_d       = state_q;
      owner_slave_d = owner_slave_q;
      last_slave_d  = last_slave_q;
      d2z_d         = d2z_q;
      turn_cnt_d    = turn_cnt_q;
      owner_req     = owner_slave_q ? slave_req : mstr_req;
      pick_slave    = 1'b0;
      tmo_fire      = 1'b0;
`ifdef BUFFER_TIMEOUT_EN
      tmo_cnt_d     = tmo_cnt_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (slave_req || mstr_req) begin
               // Round-robin on a tie: the side that did not own the last DATA wins
               pick_slave    = (slave_req && mstr_req) ? !last_slave_q : slave_req;
               owner_slave_d = pick_slave;
               d2z_d         = pick_slave ? slave_read : !mstr_read;
               state_d       = StAddr;
            end
         end
         StAddr: begin
            turn_cnt_d = 4'd1;
`ifdef BUFFER_TIMEOUT_EN
            tmo_cnt_d  = '0;
`endif
            state_d    = owner_req ? StData : StTurn;
         end
         StData: begin
`ifdef BUFFER_TIMEOUT_EN
            tmo_cnt_d = tmo_cnt_q + 6'd1;
            tmo_fire  = (tmo_cnt_q == TmoLast);
`endif
            if (cycle_end || !owner_req || tmo_fire) begin
               last_slave_d = owner_slave_q;
               turn_cnt_d   = 4'd1;
               state_d      = StTurn;
            end
         end
         StTurn: begin
            if (turn_cnt_q >= TurnMax) begin
               state_d = StIdle;
            end else begin
               turn_cnt_d = turn_cnt_q + 4'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q       <= StIdle;
         owner_slave_q <= 1'b0;
         last_slave_q  <= 1'b0;
         d2z_q         <= 1'b0;
         turn_cnt_q    <= '0;
      end else begin
         state_q       <= state_d;
         owner_slave_q <= owner_slave_d;
         last_slave_q  <= last_slave_d;
         d2z_q         <= d2z_d;
         turn_cnt_q    <= turn_cnt_d;
      end
   end

`ifdef BUFFER_TIMEOUT_EN
   always_ff @(posedge CLK) begin
      if (RESET) begin
         tmo_cnt_q <= '0;
         timeout   <= 1'b0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
         timeout   <= tmo_fire;
      end
   end
`else
   assign timeout = 1'b0;
`endif

   // Buffer pins are a registered decode of the current state
   always_ff @(posedge CLK) begin
      if (RESET) begin
         slave_gnt <= 1'b0;
         mstr_gnt  <= 1'b0;
         ABOEL_n   <= 1'b1;
         ABOEH_n   <= 1'b1;
         DBOE_n    <= 1'b1;
         D2Z_n     <= 1'b1;
         Z2D_n     <= 1'b1;
         busy      <= 1'b0;
      end else begin
         slave_gnt <= (state_q == StAddr || state_q == StData) && owner_slave_q;
         mstr_gnt  <= (state_q == StAddr || state_q == StData) && !owner_slave_q;
         ABOEL_n   <= !(state_q == StAddr || state_q == StData);
         ABOEH_n   <= !(state_q == StAddr || state_q == StData);
         DBOE_n    <= !(state_q == StData);
         D2Z_n     <= !(state_q == StData && d2z_q);
         Z2D_n     <= !(state_q == StData && !d2z_q);
         busy      <= (state_q != StIdle);
      end
   end

endmodule
